// File: rtl/alu_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_if
//   Bundles the three buses of the ALU command sequencer:
//     command stream : in_valid/in_ready, in_a, in_b, in_op, in_tag
//     ALU drive      : alu_a, alu_b, alu_op out, alu_c back
//     result stream  : out_valid/out_ready, out_c, out_tag
//     status         : busy
//   slave  = the sequencer's view, master = the surrounding system's view.
// ---------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
   parameter int DATA_W = 4,
   parameter int OP_W   = 3,
   parameter int TAG_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [OP_W-1:0]   in_op;
   logic [TAG_W-1:0]  in_tag;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_c;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_c;
   logic [TAG_W-1:0]  out_tag;

   logic              busy;

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_c,
      output out_valid, out_c, out_tag,
      input  out_ready,
      output busy
   );

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_c,
      input  out_valid, out_c, out_tag,
      output out_ready,
      input  busy
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Issue stage in front of a small ALU. Commands are buffered in a command
//   FIFO, issued one per cycle onto alu_a/alu_b/alu_op, and the ALU result
//   alu_c is captured ALU_LATENCY+1 edges after issue into a result FIFO,
//   together with the command's tag. A credit counter reserves a result slot
//   for every issued command, so results are never dropped under backpressure.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high; clears all state
//     bus   - alu_cmd_sequencer_if.slave (command stream, ALU drive,
//             result stream, busy)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int DATA_W      = 4,
   parameter int OP_W        = 3,
   parameter int TAG_W       = 4,
   parameter int DEPTH       = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   alu_cmd_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);     // FIFO index width
   localparam int PW = AW + 1;            // pointer width incl. wrap bit
   localparam int CW = $clog2(DEPTH + 1); // credit counter, 0..DEPTH

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  tag;
   } cmd_t;

   typedef struct packed {
      logic [DATA_W-1:0] c;
      logic [TAG_W-1:0]  tag;
   } res_t;

   // Command FIFO
   cmd_t          cmd_mem [DEPTH];
   logic [PW-1:0] cmd_wr_ptr;
   logic [PW-1:0] cmd_rd_ptr;
   logic          cmd_empty;
   logic          cmd_full;
   cmd_t          cmd_head;

   // Result FIFO
   res_t          res_mem [DEPTH];
   logic [PW-1:0] res_wr_ptr;
   logic [PW-1:0] res_rd_ptr;
   logic          res_empty;
   res_t          res_head;

   // Issue registers, in-flight pipe and credits
   logic [DATA_W-1:0]    alu_a_q;
   logic [DATA_W-1:0]    alu_b_q;
   logic [OP_W-1:0]      alu_op_q;
   logic [ALU_LATENCY:0] pipe_valid;
   logic [TAG_W-1:0]     pipe_tag [ALU_LATENCY+1];
   logic [CW-1:0]        credits;

   logic push;
   logic issue;
   logic res_push;
   logic pop;

   // Equal indices: the wrap bit tells full (differs) from empty (same).
   assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
   assign cmd_full  = (cmd_wr_ptr[AW] != cmd_rd_ptr[AW]) &&
                      (cmd_wr_ptr[AW-1:0] == cmd_rd_ptr[AW-1:0]);
   assign cmd_head  = cmd_mem[cmd_rd_ptr[AW-1:0]];

   assign res_empty = (res_wr_ptr == res_rd_ptr);
   assign res_head  = res_mem[res_rd_ptr[AW-1:0]];

   // in_ready looks only at the registered pointers, so a slot freed by an
   // issue in this cycle becomes usable on the next one.
   assign bus.in_ready = !cmd_full && !reset;

   assign push     = bus.in_valid && bus.in_ready;
   assign issue    = !cmd_empty && (credits != '0);
   assign res_push = pipe_valid[ALU_LATENCY];
   assign pop      = !res_empty && bus.out_ready;

   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.out_valid = !res_empty;
   assign bus.out_c     = res_head.c;
   assign bus.out_tag   = res_head.tag;
   assign bus.busy      = !cmd_empty || (|pipe_valid) || !res_empty;

   // NOTE: FIFO storage is not reset; the pointers alone decide which
   // entries are valid, so clearing the arrays would only cost logic.
   always_ff @(posedge clk) begin
      if (push) begin
         cmd_mem[cmd_wr_ptr[AW-1:0]] <= '{a: bus.in_a, b: bus.in_b,
                                          op: bus.in_op, tag: bus.in_tag};
      end
      if (res_push) begin
         res_mem[res_wr_ptr[AW-1:0]] <= '{c: bus.alu_c, tag: pipe_tag[ALU_LATENCY]};
      end
   end

   // NOTE: every state register is written with <= so all of them update
   // from the same pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         pipe_valid <= '0;
         for (int i = 0; i <= ALU_LATENCY; i++) begin
            pipe_tag[i] <= '0;
         end
         credits    <= CW'(DEPTH);
      end else begin
         if (push) begin
            cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
         end

         // Issue: pop the head into the ALU registers; they hold otherwise.
         if (issue) begin
            cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
            alu_a_q    <= cmd_head.a;
            alu_b_q    <= cmd_head.b;
            alu_op_q   <= cmd_head.op;
         end

         // Stage i holds a command issued i edges ago; the last stage marks
         // the edge on which alu_c belongs to that command.
         pipe_valid[0] <= issue;
         pipe_tag[0]   <= cmd_head.tag;
         for (int i = 1; i <= ALU_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_tag[i]   <= pipe_tag[i-1];
         end

         if (res_push) begin
            res_wr_ptr <= res_wr_ptr + PW'(1);
         end
         if (pop) begin
            res_rd_ptr <= res_rd_ptr + PW'(1);
         end

         // Credits track free result slots: issue takes one, pop returns one.
         case ({issue, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer with a registered (latency 1)
//   4-bit ALU model attached to the ALU drive bus. A scoreboard queue holds
//   the expected {c, tag} for every accepted command; results are compared
//   in order as they are popped, and held outputs are compared while stalled.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
   localparam int DATA_W      = 4;
   localparam int OP_W        = 3;
   localparam int TAG_W       = 4;
   localparam int DEPTH       = 4;
   localparam int ALU_LATENCY = 1;

   typedef struct {
      logic [3:0] c;
      logic [3:0] tag;
   } exp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] tag;
      logic [3:0] exp_c;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   alu_cmd_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

   alu_cmd_sequencer #(
      .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W),
      .DEPTH(DEPTH), .ALU_LATENCY(ALU_LATENCY)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~(a | b);
         3'd6:    return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
         default: return a << b;
      endcase
   endfunction

   // Registered ALU: samples a/b/op on an edge, c valid after that edge.
   always @(posedge clk) bus.alu_c <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       sb[$];
   int         pop_cycles[$];
   int         cyc = 0;
   int         n_pops = 0;
   logic       last_push = 1'b0;
   logic       prev_stall = 1'b0;
   logic [3:0] prev_c = '0;
   logic [3:0] prev_tag = '0;
   logic [3:0] cur_exp_c = '0;
   vec_t       vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                            input logic [3:0] tag, input logic [3:0] exp_c);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_tag   = tag;
      cur_exp_c    = exp_c;
   endtask

   // Called right after drives are set at a falling edge: evaluates the
   // handshakes that the coming rising edge will perform, then moves on to
   // the next falling edge.
   task automatic cycle();
      exp_t e;
      #1;
      if (prev_stall) begin
         check("stall_valid", bus.out_valid, 1);
         check("stall_c", bus.out_c, prev_c);
         check("stall_tag", bus.out_tag, prev_tag);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_c     = bus.out_c;
      prev_tag   = bus.out_tag;
      last_push  = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
         sb.push_back('{c: cur_exp_c, tag: bus.in_tag});
         last_push = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
         check("pop_has_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_c", bus.out_c, e.c);
            check("out_tag", bus.out_tag, e.tag);
            pop_cycles.push_back(cyc);
            n_pops++;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input string name, input int max_cyc);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int g = 0; g < max_cyc && (sb.size() != 0 || bus.busy); g++) cycle();
      check({name, "_sb_empty"}, sb.size(), 0);
      check({name, "_busy"}, bus.busy, 0);
   endtask

   // Hard stop if anything above ever hangs.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int pops0;

      // Hand-computed vectors: SUB/AND/XOR/SLT/SLL sweep plus OR/NOR/wraps.
      vecs[0] = '{a: 4'h2, b: 4'h5, op: 3'd1, tag: 4'd0, exp_c: 4'hD};
      vecs[1] = '{a: 4'hC, b: 4'hA, op: 3'd2, tag: 4'd1, exp_c: 4'h8};
      vecs[2] = '{a: 4'hC, b: 4'hA, op: 3'd4, tag: 4'd2, exp_c: 4'h6};
      vecs[3] = '{a: 4'h2, b: 4'h5, op: 3'd6, tag: 4'd3, exp_c: 4'h1};
      vecs[4] = '{a: 4'h3, b: 4'h2, op: 3'd7, tag: 4'd4, exp_c: 4'hC};
      vecs[5] = '{a: 4'hC, b: 4'hA, op: 3'd3, tag: 4'd5, exp_c: 4'hE};
      vecs[6] = '{a: 4'hC, b: 4'hA, op: 3'd5, tag: 4'd6, exp_c: 4'h1};
      vecs[7] = '{a: 4'hF, b: 4'h1, op: 3'd0, tag: 4'd7, exp_c: 4'h0};
      vecs[8] = '{a: 4'h5, b: 4'h2, op: 3'd6, tag: 4'd8, exp_c: 4'h0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // ---- reset state ----
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check("rst_alu_op", bus.alu_op, 0);
      reset = 1'b0;
      #1;
      check("rel_in_ready", bus.in_ready, 1);
      check("rel_credits", dut.credits, DEPTH);
      @(negedge clk);

      // ---- single ADD 3+5, tag 1, out_ready=1 ----
      drive_cmd(4'd3, 4'd5, 3'd0, 4'd1, 4'd8);
      cycle();                              // after push edge N
      bus.in_valid = 1'b0;
      check("add_busy", bus.busy, 1);
      check("add_out_valid_n", bus.out_valid, 0);
      cycle();                              // after N+1: issued
      check("add_alu_a", bus.alu_a, 3);
      check("add_alu_b", bus.alu_b, 5);
      check("add_alu_op", bus.alu_op, 0);
      check("add_out_valid_n1", bus.out_valid, 0);
      cycle();                              // after N+2
      check("add_out_valid_n2", bus.out_valid, 0);
      cycle();                              // after N+3: captured
      check("add_out_valid_n3", bus.out_valid, 1);
      check("add_out_c", bus.out_c, 8);
      check("add_out_tag", bus.out_tag, 1);
      cycle();                              // popped
      check("add_busy_after_pop", bus.busy, 0);
      check("add_out_valid_after_pop", bus.out_valid, 0);

      // ---- op sweep, back-to-back ----
      pop_cycles.delete();
      pops0 = n_pops;
      for (int i = 0; i < 9; i++) begin
         drive_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, vecs[i].exp_c);
         cycle();
         check("sweep_accept", last_push, 1);
      end
      drain("sweep", 20);
      check("sweep_pops", n_pops - pops0, 9);
      for (int i = 1; i < pop_cycles.size(); i++) begin
         check("sweep_consecutive", pop_cycles[i] - pop_cycles[i-1], 1);
      end
      check("sweep_credits", dut.credits, DEPTH);

      // ---- backpressure: 10 commands, out_ready low ----
      bus.out_ready = 1'b0;
      acc = 0;
      pops0 = n_pops;
      drive_cmd(4'd0, 4'd1, 3'd0, 4'd0, alu_f(4'd0, 4'd1, 3'd0));
      for (int g = 0; g < 20; g++) begin
         cycle();
         if (last_push) begin
            acc++;
            if (acc < 10) drive_cmd(4'(acc), 4'(acc + 1), 3'(acc), 4'(acc),
                                    alu_f(4'(acc), 4'(acc + 1), 3'(acc)));
            else bus.in_valid = 1'b0;
         end
      end
      check("bp_accepted", acc, 8);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      for (int g = 0; g < 60 && !(acc == 10 && sb.size() == 0); g++) begin
         cycle();
         if (last_push) begin
            acc++;
            if (acc < 10) drive_cmd(4'(acc), 4'(acc + 1), 3'(acc), 4'(acc),
                                    alu_f(4'(acc), 4'(acc + 1), 3'(acc)));
            else bus.in_valid = 1'b0;
         end
      end
      check("bp_all_accepted", acc, 10);
      drain("bp", 20);
      check("bp_pops", n_pops - pops0, 10);

      // ---- random out_ready, 200 random commands ----
      acc = 0;
      pops0 = n_pops;
      begin
         int offered = 0;
         bus.in_valid = 1'b0;
         for (int g = 0; g < 6000 && !(acc == 200 && sb.size() == 0); g++) begin
            if (!bus.in_valid && offered < 200 && $urandom_range(0, 9) < 7) begin
               logic [3:0] ra;
               logic [3:0] rb;
               logic [2:0] rop;
               ra  = 4'($urandom_range(0, 15));
               rb  = 4'($urandom_range(0, 15));
               rop = 3'($urandom_range(0, 7));
               drive_cmd(ra, rb, rop, 4'(offered), alu_f(ra, rb, rop));
               offered++;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_push) begin
               acc++;
               bus.in_valid = 1'b0;
            end
         end
      end
      check("rand_accepted", acc, 200);
      check("rand_pops", n_pops - pops0, 200);
      drain("rand", 20);

      // ---- reset mid-operation ----
      bus.out_ready = 1'b0;
      acc = 0;
      drive_cmd(4'd1, 4'd1, 3'd0, 4'd0, 4'd2);
      for (int g = 0; g < 30; g++) begin
         cycle();
         if (last_push) begin
            acc++;
            if (acc < 8) drive_cmd(4'd1, 4'(acc), 3'd0, 4'(acc), 4'(acc + 1));
            else bus.in_valid = 1'b0;
         end
      end
      check("mid_fill", acc, 8);
      bus.out_ready = 1'b1;                 // two pops free two credits
      cycle();
      cycle();
      bus.out_ready = 1'b0;
      drive_cmd(4'd2, 4'd2, 3'd0, 4'd8, 4'd4);
      cycle();                              // cmd 3, in flight 2, results 2
      check("mid_push", last_push, 1);
      bus.in_valid = 1'b0;
      check("mid_busy_before", bus.busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      sb.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("mid_rel_busy", bus.busy, 0);
      check("mid_rel_in_ready", bus.in_ready, 1);
      check("mid_rel_credits", dut.credits, DEPTH);
      for (int g = 0; g < 5; g++) begin
         cycle();
         check("mid_no_out_valid", bus.out_valid, 0);
      end
      pops0 = n_pops;
      drive_cmd(4'd7, 4'd6, 3'd0, 4'd9, 4'hD);
      cycle();
      drain("mid_after", 20);
      check("mid_after_pops", n_pops - pops0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
